// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit
//  Purpose  : PC sequencer for the single-cycle MIPS core: boot/run/halt
//             control, stall hold, out-of-range fetch fault, retired count.
//  Options  : PC_HALT_DETECT_EN -- a taken jump/branch to its own PC halts.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned IMEM_BYTES   = 128,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  Stall,
  input  logic                  Zero,
  input  logic                  Branch,
  input  logic                  Jump,
  input  logic [31:0]           SEImm,
  input  logic [25:0]           JumpValue,
  output logic [ADDR_WIDTH-1:0] ReadAddr,
  output logic [ADDR_WIDTH-1:0] PC_Plus4,
  output logic                  Halted,
  output logic                  AddrFault,
  output logic [15:0]           InstrCount
);

  localparam logic [1:0] c_st_boot = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_halt = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] c_reset_pc = ADDR_WIDTH'(RESET_VECTOR);
  localparam logic [ADDR_WIDTH-1:0] c_pc_step  = ADDR_WIDTH'(4);
  localparam logic [15:0]           c_cnt_max  = 16'hFFFF;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [15:0]           r_instr_count;
  logic                  r_addr_fault;
  logic                  r_halted;

  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic [ADDR_WIDTH-1:0] w_jump_target;
  logic [ADDR_WIDTH-1:0] w_branch_target;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic                  w_branch_taken;
  logic                  w_fault;
  logic                  w_self_hit;

  // All target arithmetic is cast straight to the PC width so carries and
  // upper immediate bits fall away, giving modulo-2^ADDR_WIDTH behaviour.
  always_comb begin
    w_pc_plus4      = r_pc + c_pc_step;
    w_jump_target   = ADDR_WIDTH'({JumpValue, 2'b00});
    w_branch_target = w_pc_plus4 + ADDR_WIDTH'(SEImm << 2);
    w_branch_taken  = Branch & Zero;
    w_next_pc       = w_pc_plus4;
    if (Jump) begin
      w_next_pc = w_jump_target;
    end else if (w_branch_taken) begin
      w_next_pc = w_branch_target;
    end
  end

  // Widened compare so an IMEM_BYTES at or beyond 2^ADDR_WIDTH never faults.
  assign w_fault = (64'(w_next_pc) >= 64'(IMEM_BYTES));

`ifdef PC_HALT_DETECT_EN
  assign w_self_hit = (Jump | w_branch_taken) & (w_next_pc == r_pc);
`else
  assign w_self_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= c_st_boot;
      r_pc          <= c_reset_pc;
      r_instr_count <= 16'd0;
      r_addr_fault  <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        c_st_boot: begin
          r_state <= c_st_run;
        end
        c_st_run: begin
          if (!Stall) begin
            // The faulting or self-targeting transition still retires.
            r_pc <= w_next_pc;
            if (r_instr_count != c_cnt_max) begin
              r_instr_count <= r_instr_count + 16'd1;
            end
            if (w_fault) begin
              r_addr_fault <= 1'b1;
              r_state      <= c_st_halt;
              r_halted     <= 1'b1;
            end else if (w_self_hit) begin
              r_state  <= c_st_halt;
              r_halted <= 1'b1;
            end
          end
        end
        c_st_halt: begin
          r_state <= c_st_halt;
        end
        default: begin
          r_state  <= c_st_halt;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  assign ReadAddr   = r_pc;
  assign PC_Plus4   = w_pc_plus4;
  assign Halted     = r_halted;
  assign AddrFault  = r_addr_fault;
  assign InstrCount = r_instr_count;

endmodule
`default_nettype wire
